// File: rtl/cmd_queue_sync_pkg.sv
// rtl/cmd_queue_sync_pkg.sv - shared DDR command codes and queue entry sizing
package cmd_queue_sync_pkg;

  localparam int CMD_TYPE_W = 2;

  typedef enum logic [CMD_TYPE_W-1:0] {
    CMD_RD    = 2'd0,
    CMD_WR    = 2'd1,
    CMD_RSVD2 = 2'd2,
    CMD_RSVD3 = 2'd3
  } cmd_type_e;

  // Entry packing is {cmd_type, addr, burst_cnt, wt_data, wt_mask}, MSB first.
  function automatic int entry_width(int addr_w, int burst_w, int data_w);
    return CMD_TYPE_W + addr_w + burst_w + data_w + data_w / 8;
  endfunction

endpackage

// File: rtl/cmd_queue_sync_if.sv
// rtl/cmd_queue_sync_if.sv - push/pop/status bundle for cmd_queue_sync
// Optional: CMD_QUEUE_STATS_EN adds io_stat_peak and io_stat_drop.
interface cmd_queue_sync_if
  import cmd_queue_sync_pkg::*;
#(
  parameter int ADDR_W  = 27,
  parameter int BURST_W = 6,
  parameter int DATA_W  = 128,
  parameter int DEPTH   = 16
);
  localparam int MASK_W = DATA_W / 8;
  localparam int LVL_W  = $clog2(DEPTH + 1);

  logic                  io_flush;
  logic                  io_push_valid;
  logic                  io_push_ready;
  logic [CMD_TYPE_W-1:0] io_push_cmd_type;
  logic [ADDR_W-1:0]     io_push_addr;
  logic [BURST_W-1:0]    io_push_burst_cnt;
  logic [DATA_W-1:0]     io_push_wt_data;
  logic [MASK_W-1:0]     io_push_wt_mask;
  logic                  io_pop_valid;
  logic                  io_pop_ready;
  logic [CMD_TYPE_W-1:0] io_pop_cmd_type;
  logic [ADDR_W-1:0]     io_pop_addr;
  logic [BURST_W-1:0]    io_pop_burst_cnt;
  logic [DATA_W-1:0]     io_pop_wt_data;
  logic [MASK_W-1:0]     io_pop_wt_mask;
  logic [LVL_W-1:0]      io_level;
  logic                  io_almost_full;
`ifdef CMD_QUEUE_STATS_EN
  logic [LVL_W-1:0]      io_stat_peak;
  logic [15:0]           io_stat_drop;
`endif

  modport slave (
    input  io_flush, io_push_valid, io_push_cmd_type, io_push_addr, io_push_burst_cnt,
           io_push_wt_data, io_push_wt_mask, io_pop_valid,
    output io_push_ready, io_pop_ready, io_pop_cmd_type, io_pop_addr, io_pop_burst_cnt,
           io_pop_wt_data, io_pop_wt_mask, io_level, io_almost_full
`ifdef CMD_QUEUE_STATS_EN
    , output io_stat_peak, io_stat_drop
`endif
  );

  modport master (
    output io_flush, io_push_valid, io_push_cmd_type, io_push_addr, io_push_burst_cnt,
           io_push_wt_data, io_push_wt_mask, io_pop_valid,
    input  io_push_ready, io_pop_ready, io_pop_cmd_type, io_pop_addr, io_pop_burst_cnt,
           io_pop_wt_data, io_pop_wt_mask, io_level, io_almost_full
`ifdef CMD_QUEUE_STATS_EN
    , input io_stat_peak, io_stat_drop
`endif
  );

endinterface

// File: rtl/cmd_queue_sync_ram.sv
// rtl/cmd_queue_sync_ram.sv - cmd_queue_ram: DEPTH x WIDTH, sync write, async read
module cmd_queue_ram #(
  parameter int WIDTH = 179,
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [PTR_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [PTR_W-1:0] rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/cmd_queue_sync.sv
// rtl/cmd_queue_sync.sv - single-clock FWFT command queue with level, almost-full and flush
// Optional: CMD_QUEUE_STATS_EN adds peak-level and dropped-push statistics.
module cmd_queue_sync
  import cmd_queue_sync_pkg::*;
#(
  parameter int ADDR_W    = 27,
  parameter int BURST_W   = 6,
  parameter int DATA_W    = 128,
  parameter int DEPTH     = 16,
  parameter int AFULL_LVL = DEPTH - 2
) (
  input  logic            clk,
  input  logic            rstn,
  cmd_queue_sync_if.slave bus
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LVL_W   = $clog2(DEPTH + 1);
  localparam int ENTRY_W = entry_width(ADDR_W, BURST_W, DATA_W);

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               full, empty;
  logic               push_ready, pop_ready;
  logic               push_fire, pop_fire;
  logic [ENTRY_W-1:0] wr_entry, rd_entry;

  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);

  // rstn enters the readies directly so they drop the instant reset asserts.
  assign push_ready = rstn && !full;
  assign pop_ready  = rstn && !empty;

  // Flush wins over both handshakes; an entry offered alongside it is dropped.
  assign push_fire = bus.io_push_valid && push_ready && !bus.io_flush;
  assign pop_fire  = bus.io_pop_valid && pop_ready && !bus.io_flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (bus.io_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_fire)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      level_d = level_q + LVL_W'(push_fire) - LVL_W'(pop_fire);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign wr_entry = {bus.io_push_cmd_type, bus.io_push_addr, bus.io_push_burst_cnt,
                     bus.io_push_wt_data, bus.io_push_wt_mask};

  cmd_queue_ram #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (push_fire),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (wr_entry),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rd_entry)
  );

  assign {bus.io_pop_cmd_type, bus.io_pop_addr, bus.io_pop_burst_cnt,
          bus.io_pop_wt_data, bus.io_pop_wt_mask} = rd_entry;

  assign bus.io_push_ready  = push_ready;
  assign bus.io_pop_ready   = pop_ready;
  assign bus.io_level       = level_q;
  assign bus.io_almost_full = (level_q >= LVL_W'(AFULL_LVL));

`ifdef CMD_QUEUE_STATS_EN
  logic [LVL_W-1:0] peak_q, peak_d;
  logic [15:0]      drop_q, drop_d;

  // Peak tracks the level being loaded, so it is never behind io_level; flush leaves it alone.
  always_comb begin
    peak_d = peak_q;
    drop_d = drop_q;
    if (level_d > peak_q) peak_d = level_d;
    if (bus.io_push_valid && !push_ready && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      peak_q <= '0;
      drop_q <= '0;
    end else begin
      peak_q <= peak_d;
      drop_q <= drop_d;
    end
  end

  assign bus.io_stat_peak = peak_q;
  assign bus.io_stat_drop = drop_q;
`endif

endmodule

// File: tb/tb_cmd_queue_sync.sv
// tb/tb_cmd_queue_sync.sv - randomized queue-model check of cmd_queue_sync plus directed cases
module tb_cmd_queue_sync;
  import cmd_queue_sync_pkg::*;

  localparam int ADDR_W  = 27;
  localparam int BURST_W = 6;
  localparam int DATA_W  = 128;
  localparam int MASK_W  = DATA_W / 8;
  localparam int DEPTH   = 16;
  localparam int EW      = CMD_TYPE_W + ADDR_W + BURST_W + DATA_W + MASK_W;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  cmd_queue_sync_if #(.ADDR_W(ADDR_W), .BURST_W(BURST_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  cmd_queue_sync #(.ADDR_W(ADDR_W), .BURST_W(BURST_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [EW-1:0] model_q[$];
  int            peak_m = 0;
  int            drop_m = 0;
  int            sz_m;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a plain queue of packed entries, capacity DEPTH.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      model_q.delete();
      peak_m = 0;
      drop_m = 0;
    end else begin
      sz_m = model_q.size();
      if (bus.io_push_valid && sz_m >= DEPTH && drop_m < 65535) drop_m = drop_m + 1;
      if (bus.io_flush) begin
        model_q.delete();
      end else begin
        if (bus.io_pop_valid && sz_m > 0) void'(model_q.pop_front());
        if (bus.io_push_valid && sz_m < DEPTH)
          model_q.push_back({bus.io_push_cmd_type, bus.io_push_addr, bus.io_push_burst_cnt,
                             bus.io_push_wt_data, bus.io_push_wt_mask});
      end
      if (model_q.size() > peak_m) peak_m = model_q.size();
    end
  end

  always @(negedge clk) begin
    check("push_ready", 256'(bus.io_push_ready), 256'(rstn && model_q.size() < DEPTH));
    check("pop_ready", 256'(bus.io_pop_ready), 256'(rstn && model_q.size() > 0));
    check("level", 256'(bus.io_level), 256'(model_q.size()));
    check("almost_full", 256'(bus.io_almost_full), 256'(model_q.size() >= DEPTH - 2));
    if (model_q.size() > 0)
      check("head", 256'({bus.io_pop_cmd_type, bus.io_pop_addr, bus.io_pop_burst_cnt,
                          bus.io_pop_wt_data, bus.io_pop_wt_mask}), 256'(model_q[0]));
`ifdef CMD_QUEUE_STATS_EN
    check("stat_peak", 256'(bus.io_stat_peak), 256'(peak_m));
    check("stat_drop", 256'(bus.io_stat_drop), 256'(drop_m));
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.io_flush      = 1'b0;
    bus.io_push_valid = 1'b0;
    bus.io_pop_valid  = 1'b0;
  endtask

  task automatic rand_entry(input logic [ADDR_W-1:0] addr);
    bus.io_push_cmd_type  = CMD_TYPE_W'($urandom_range(0, 3));
    bus.io_push_addr      = addr;
    bus.io_push_burst_cnt = BURST_W'($urandom);
    bus.io_push_wt_data   = {$urandom, $urandom, $urandom, $urandom};
    bus.io_push_wt_mask   = MASK_W'($urandom);
  endtask

  task automatic push_n(input int n);
    for (int i = 0; i < n; i++) begin
      rand_entry(ADDR_W'($urandom));
      bus.io_push_valid = 1'b1;
      step();
    end
    bus.io_push_valid = 1'b0;
  endtask

  initial begin
    set_idle();
    rand_entry('0);
    repeat (2) step();
    check("rst_push_ready", 256'(bus.io_push_ready), 256'(0));
    check("rst_pop_ready", 256'(bus.io_pop_ready), 256'(0));
    check("rst_level", 256'(bus.io_level), 256'(0));
    check("rst_afull", 256'(bus.io_almost_full), 256'(0));
    rstn = 1'b1;
    step();
    check("post_rst_push_ready", 256'(bus.io_push_ready), 256'(1));

    // FIFO order with addresses 0x10/0x20/0x30
    for (int i = 0; i < 3; i++) begin
      rand_entry(ADDR_W'(16 * (i + 1)));
      bus.io_push_valid = 1'b1;
      step();
      check("t1_level_up", 256'(bus.io_level), 256'(i + 1));
    end
    bus.io_push_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t1_addr", 256'(bus.io_pop_addr), 256'(16 * (i + 1)));
      bus.io_pop_valid = 1'b1;
      step();
      check("t1_level_down", 256'(bus.io_level), 256'(2 - i));
    end
    bus.io_pop_valid = 1'b0;
    check("t1_pop_ready_end", 256'(bus.io_pop_ready), 256'(0));

    // Fill to DEPTH, almost-full from 14, 17th push dropped
    for (int i = 0; i < DEPTH; i++) begin
      check("t2_afull", 256'(bus.io_almost_full), 256'(i >= 14));
      rand_entry(ADDR_W'($urandom));
      bus.io_push_valid = 1'b1;
      step();
    end
    check("t2_level", 256'(bus.io_level), 256'(16));
    check("t2_push_ready", 256'(bus.io_push_ready), 256'(0));
    check("t2_afull_full", 256'(bus.io_almost_full), 256'(1));
    rand_entry(ADDR_W'($urandom));
    step();
    bus.io_push_valid = 1'b0;
    check("t2_level_17th", 256'(bus.io_level), 256'(16));
`ifdef CMD_QUEUE_STATS_EN
    check("t2_drop", 256'(bus.io_stat_drop), 256'(1));
`endif

    // Full with simultaneous push and pop: only the pop fires
    rand_entry(ADDR_W'($urandom));
    bus.io_push_valid = 1'b1;
    bus.io_pop_valid  = 1'b1;
    step();
    check("t3_level", 256'(bus.io_level), 256'(15));
    bus.io_pop_valid = 1'b0;
    rand_entry(ADDR_W'($urandom));
    step();
    check("t3_level_refill", 256'(bus.io_level), 256'(16));
    bus.io_push_valid = 1'b0;
    bus.io_pop_valid  = 1'b1;
    repeat (DEPTH) step();
    bus.io_pop_valid = 1'b0;
    check("t3_drained", 256'(bus.io_level), 256'(0));

    // Interleaved random traffic across pointer wrap
    for (int i = 0; i < 40; i++) begin
      rand_entry(ADDR_W'($urandom));
      bus.io_push_valid = 1'($urandom);
      bus.io_pop_valid  = 1'($urandom);
      step();
    end
    for (int i = 0; i < 400; i++) begin
      rand_entry(ADDR_W'($urandom));
      bus.io_push_valid = ($urandom_range(0, 99) < (i < 200 ? 65 : 40));
      bus.io_pop_valid  = ($urandom_range(0, 99) < 50);
      bus.io_flush      = ($urandom_range(0, 31) == 0);
      step();
    end
    set_idle();
    step();

    // Flush beats push and pop at level 5
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    step();
    push_n(5);
    check("t5_level5", 256'(bus.io_level), 256'(5));
    rand_entry(ADDR_W'($urandom));
    bus.io_push_valid = 1'b1;
    bus.io_pop_valid  = 1'b1;
    bus.io_flush      = 1'b1;
    step();
    set_idle();
    check("t5_level", 256'(bus.io_level), 256'(0));
    check("t5_pop_ready", 256'(bus.io_pop_ready), 256'(0));
`ifdef CMD_QUEUE_STATS_EN
    check("t5_peak", 256'(bus.io_stat_peak), 256'(5));
`endif

    // Async reset mid-burst at level 7
    push_n(7);
    check("t6_level7", 256'(bus.io_level), 256'(7));
    rand_entry(ADDR_W'($urandom));
    bus.io_push_valid = 1'b1;
    bus.io_pop_valid  = 1'b1;
    #1;
    rstn = 1'b0;
    #1;
    check("t6_push_ready", 256'(bus.io_push_ready), 256'(0));
    check("t6_pop_ready", 256'(bus.io_pop_ready), 256'(0));
    check("t6_level", 256'(bus.io_level), 256'(0));
`ifdef CMD_QUEUE_STATS_EN
    check("t6_drop", 256'(bus.io_stat_drop), 256'(0));
`endif
    set_idle();
    step();
    rstn = 1'b1;
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
